// File: rtl/dest_sb_pkg.sv
// Shared constants and types for the destination-register scoreboard.
// Register 0 is hard-wired and never tracked.
package dest_sb_pkg;
   localparam int AW   = 5;
   localparam int NREG = 1 << AW;
   localparam int CW   = 2;
   localparam int OW   = 7;

   typedef logic [AW-1:0]   addr_t;
   typedef logic [NREG-1:0] vec_t;
   typedef logic [CW-1:0]   cnt_t;
   typedef logic [OW-1:0]   out_t;

   localparam cnt_t  CNT_MAX  = '1;
   localparam addr_t REG_ZERO = '0;
endpackage

// File: rtl/dest_scoreboard_if.sv
// Issue, writeback and operand-lookup bundle of the scoreboard.
// master drives requests, slave is the scoreboard itself.
interface dest_scoreboard_if;
   import dest_sb_pkg::*;

   logic  issue_valid;
   addr_t issue_dest;
   logic  issue_ready;
   logic  wb_valid;
   addr_t wb_dest;
   addr_t rs_addr;
   addr_t rt_addr;
   logic  rs_busy;
   logic  rt_busy;
   logic  stall;
   vec_t  wb_we;
   vec_t  busy_vec;
   out_t  outstanding;
   logic  err;

   modport master (
      output issue_valid, issue_dest, wb_valid, wb_dest,
      output rs_addr, rt_addr,
      input  issue_ready, rs_busy, rt_busy, stall,
      input  wb_we, busy_vec, outstanding, err
   );

   modport slave (
      input  issue_valid, issue_dest, wb_valid, wb_dest,
      input  rs_addr, rt_addr,
      output issue_ready, rs_busy, rt_busy, stall,
      output wb_we, busy_vec, outstanding, err
   );
endinterface

// File: rtl/dest_scoreboard_decoder.sv
// Address to one-hot decoder; mirrors the write-register select mux.
// Address 0 never produces a strobe.
module dest_decoder
   import dest_sb_pkg::*;
(
   input  logic  en,
   input  addr_t addr,
   output vec_t  onehot
);

   // one bit per register, suppressed for register 0
   always_comb begin
      onehot = '0;
      if (en && addr != REG_ZERO)
         onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/dest_scoreboard.sv
// Per-register pending-write counters with issue back-pressure,
// operand busy lookup and a registered writeback enable.
module dest_scoreboard
   import dest_sb_pkg::*;
(
   input logic              clk,
   input logic              rst,
   dest_scoreboard_if.slave sb
);

   cnt_t [NREG-1:0] count;
   vec_t inc_vec;
   vec_t dec_vec;
   vec_t we_next;
   vec_t we_q;
   vec_t busy;
   out_t total;
   logic err_q;
   logic ready;
   logic inc;
   logic dec;
   logic bad;

   // accept/inc/dec qualification from the registered counts
   always_comb begin
      ready = (sb.issue_dest == REG_ZERO)
           || (count[sb.issue_dest] != CNT_MAX)
           || (sb.wb_valid && sb.wb_dest == sb.issue_dest);
      inc = sb.issue_valid && ready
         && sb.issue_dest != REG_ZERO;
      dec = sb.wb_valid && sb.wb_dest != REG_ZERO
         && count[sb.wb_dest] != '0;
      bad = sb.wb_valid && sb.wb_dest != REG_ZERO
         && count[sb.wb_dest] == '0;
   end

   dest_decoder u_inc (
      .en     (inc),
      .addr   (sb.issue_dest),
      .onehot (inc_vec)
   );

   dest_decoder u_dec (
      .en     (dec),
      .addr   (sb.wb_dest),
      .onehot (dec_vec)
   );

   dest_decoder u_we (
      .en     (sb.wb_valid),
      .addr   (sb.wb_dest),
      .onehot (we_next)
   );

   // per-register counters; simultaneous inc and dec cancel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         count[0] <= '0;
         for (int i = 1; i < NREG; i++) begin
            if (inc_vec[i] && !dec_vec[i])
               count[i] <= count[i] + 1'b1;
            else if (dec_vec[i] && !inc_vec[i])
               count[i] <= count[i] - 1'b1;
         end
      end
   end

   // write enable, running total and sticky underflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q  <= '0;
         total <= '0;
         err_q <= 1'b0;
      end else begin
         we_q  <= we_next;
         total <= total + OW'(inc) - OW'(dec);
         if (bad)
            err_q <= 1'b1;
      end
   end

   // busy view of the registered counts
   always_comb begin
      busy = '0;
      for (int i = 0; i < NREG; i++)
         busy[i] = count[i] != '0;
   end

   assign sb.issue_ready = ready;
   assign sb.rs_busy     = sb.rs_addr != REG_ZERO
                        && busy[sb.rs_addr];
   assign sb.rt_busy     = sb.rt_addr != REG_ZERO
                        && busy[sb.rt_addr];
   assign sb.stall       = sb.rs_busy || sb.rt_busy
                        || (sb.issue_valid && !ready);
   assign sb.wb_we       = we_q;
   assign sb.busy_vec    = busy;
   assign sb.outstanding = total;
   assign sb.err         = err_q;

endmodule
